// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Frames a UART byte stream (AA, LEN_LO, LEN_HI, 4*N data, XOR csum)
//            into inst_fetch loader strobes and reports done/error status.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int TIMEOUT        = 100000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] input_data,
  output logic       input_valid,
  output logic       input_start,
  output logic       input_end,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int              TMR_W       = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);
  localparam logic [16:0]     c_max_words = 17'd1 << INST_MEM_WIDTH;
  localparam logic [7:0]      c_magic     = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t             r_state,    w_state;
  logic [7:0]         r_len_lo,   w_len_lo;
  logic [15:0]        r_nwords,   w_nwords;
  logic [7:0]         r_csum,     w_csum;
  logic [17:0]        r_byte_cnt, w_byte_cnt;
  logic [TMR_W-1:0]   r_tmr,      w_tmr;
  logic [7:0]         r_data,     w_data;
  logic               r_valid,    w_valid;
  logic               r_start,    w_start;
  logic               r_end,      w_end;
  logic               r_busy,     w_busy;
  logic               r_done,     w_done;
  logic               r_error,    w_error;

  logic [15:0]        w_len_word;
  logic               w_len_bad;
  logic [17:0]        w_total;
  logic [17:0]        w_cnt_inc;
  logic               w_expire;

  assign w_len_word = {rx_data, r_len_lo};
  assign w_len_bad  = (w_len_word == 16'd0) || ({1'b0, w_len_word} > c_max_words);
  assign w_total    = {r_nwords, 2'b00};
  assign w_cnt_inc  = r_byte_cnt + 18'd1;
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_expire   = (r_state != S_IDLE) && !rx_valid && (r_tmr == c_tmr_last);

  always_comb begin
    w_state    = r_state;
    w_len_lo   = r_len_lo;
    w_nwords   = r_nwords;
    w_csum     = r_csum;
    w_byte_cnt = r_byte_cnt;
    w_data     = r_data;
    w_valid    = 1'b0;
    w_start    = 1'b0;
    w_end      = 1'b0;
    w_done     = r_done;
    w_error    = r_error;
    w_tmr      = (r_state == S_IDLE || rx_valid) ? '0 : r_tmr + TMR_W'(1);

    case (r_state)
      S_IDLE: begin
        if (rx_valid && rx_data == c_magic) begin
          w_state    = S_LEN0;
          w_done     = 1'b0;
          w_error    = 1'b0;
          w_csum     = 8'h00;
          w_byte_cnt = 18'd0;
        end
      end
      S_LEN0: begin
        if (rx_valid) begin
          w_len_lo = rx_data;
          w_state  = S_LEN1;
        end else if (w_expire) begin
          w_error = 1'b1;
          w_state = S_IDLE;
        end
      end
      S_LEN1: begin
        if (rx_valid) begin
          w_nwords = w_len_word;
          if (w_len_bad) begin
            w_error = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_start = 1'b1;
            w_state = S_DATA;
          end
        end else if (w_expire) begin
          w_error = 1'b1;
          w_state = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          w_data     = rx_data;
          w_valid    = 1'b1;
          w_csum     = r_csum ^ rx_data;
          w_byte_cnt = w_cnt_inc;
          if (w_cnt_inc == w_total) w_state = S_CSUM;
        end else if (w_expire) begin
          // Load already opened: close it so inst_fetch leaves load mode.
          w_error = 1'b1;
          w_end   = 1'b1;
          w_state = S_IDLE;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          w_end   = 1'b1;
          w_done  = (rx_data == r_csum);
          w_error = (rx_data != r_csum);
          w_state = S_IDLE;
        end else if (w_expire) begin
          w_error = 1'b1;
          w_end   = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_len_lo   <= 8'h00;
      r_nwords   <= 16'h0000;
      r_csum     <= 8'h00;
      r_byte_cnt <= 18'd0;
      r_tmr      <= '0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_start    <= 1'b0;
      r_end      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_len_lo   <= w_len_lo;
      r_nwords   <= w_nwords;
      r_csum     <= w_csum;
      r_byte_cnt <= w_byte_cnt;
      r_tmr      <= w_tmr;
      r_data     <= w_data;
      r_valid    <= w_valid;
      r_start    <= w_start;
      r_end      <= w_end;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_error    <= w_error;
    end
  end

  assign input_data  = r_data;
  assign input_valid = r_valid;
  assign input_start = r_start;
  assign input_end   = r_end;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Scoreboard bench for program_loader with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int IMW = 2;
  localparam int TO  = 50;
  localparam int K_START = 0;
  localparam int K_VALID = 1;
  localparam int K_END   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] input_data;
  logic       input_valid, input_start, input_end, busy, done, error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int last_end_cyc = 0;
  ev_t exp_q[$];
  logic exp_done = 1'b0;
  logic exp_error = 1'b0;

  program_loader #(.INST_MEM_WIDTH(IMW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .input_data(input_data), .input_valid(input_valid),
    .input_start(input_start), .input_end(input_end),
    .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe: got kind %0d data %0h expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_VALID && e.data !== data)) begin
        errors++;
        $display("FAIL strobe: got kind %0d data %0h expected kind %0d data %0h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  function automatic void push(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Monitor: every strobe seen must match the head of the expected queue.
  always @(negedge CLK) begin
    if (reset) begin
      int n;
      n = int'(input_start) + int'(input_valid) + int'(input_end);
      if (n > 1) check("strobe_overlap", n, 1);
      if (input_start) expect_ev(K_START, 8'h00);
      if (input_valid) begin
        expect_ev(K_VALID, input_data);
        last_valid_cyc = cyc;
      end
      if (input_end) begin
        expect_ev(K_END, 8'h00);
        last_end_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge CLK);
  endtask

  task automatic check_status(input string tag);
    repeat (3) @(negedge CLK);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_error);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  // Frame model: in-range lengths load 4*N bytes and close with input_end;
  // out-of-range lengths only raise error.
  task automatic run_frame(input int nw, input logic [7:0] data[$], input bit corrupt,
                           input int noise, input string tag);
    logic [7:0] cs;
    logic [7:0] cb;
    logic [15:0] len;
    len = 16'(nw);
    for (int i = 0; i < noise; i++) send_byte(8'($urandom_range(0, 8'hA9)));
    send_byte(8'hAA);
    exp_done = 1'b0;
    exp_error = 1'b0;
    send_byte(len[7:0]);
    if (nw == 0 || nw > (1 << IMW)) begin
      exp_error = 1'b1;
      send_byte(len[15:8]);
    end else begin
      push(K_START, 8'h00);
      send_byte(len[15:8]);
      cs = 8'h00;
      for (int i = 0; i < 4 * nw; i++) begin
        cs ^= data[i];
        push(K_VALID, data[i]);
        send_byte(data[i]);
      end
      cb = corrupt ? (cs ^ 8'($urandom_range(1, 255))) : cs;
      push(K_END, 8'h00);
      send_byte(cb);
      exp_done = !corrupt;
      exp_error = corrupt;
    end
    check_status(tag);
  endtask

  initial begin
    logic [7:0] dq[$];
    logic       seen;
    int         t0;

    repeat (3) @(negedge CLK);
    check("rst_data", input_data, 8'h00);
    check("rst_strobes", {input_valid, input_start, input_end}, 3'b000);
    check("rst_status", {busy, done, error}, 3'b000);
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    dq = '{8'h04, 8'h10, 8'hC2, 8'h00};
    run_frame(1, dq, 1'b0, 0, "good");
    run_frame(1, dq, 1'b1, 0, "badcsum");
    run_frame(5, dq, 1'b0, 0, "len5");
    run_frame(0, dq, 1'b0, 0, "len0");
    run_frame(1, dq, 1'b0, 2, "rearm");

    for (int f = 0; f < 8; f++) begin
      int nw;
      nw = (f == 3) ? 4 : $urandom_range(1, 4);
      dq.delete();
      for (int i = 0; i < 4 * nw; i++) dq.push_back(8'($urandom));
      run_frame(nw, dq, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), "rand");
    end

    // Timeout in DATA: input_end follows the last data strobe by TO cycles.
    push(K_START, 8'h00);
    push(K_VALID, 8'h04);
    push(K_VALID, 8'h10);
    push(K_END, 8'h00);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h04);
    t0 = last_end_cyc;
    send_byte(8'h10);
    seen = 1'b0;
    for (int i = 0; i < TO + 20 && !seen; i++) begin
      @(negedge CLK);
      if (last_end_cyc != t0) seen = 1'b1;
    end
    check("timeout_seen", seen, 1);
    check("timeout_delay", last_end_cyc - last_valid_cyc, TO);
    exp_done = 1'b0;
    exp_error = 1'b1;
    check_status("timeout");

    // Reset mid-frame after the second data byte.
    push(K_START, 8'h00);
    push(K_VALID, 8'h04);
    push(K_VALID, 8'h10);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h10);
    #2 reset = 1'b0;
    #1;
    check("midrst_data", input_data, 8'h00);
    check("midrst_strobes", {input_valid, input_start, input_end}, 3'b000);
    check("midrst_status", {busy, done, error}, 3'b000);
    check("midrst_queue", exp_q.size(), 0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    dq = '{8'h04, 8'h10, 8'hC2, 8'h00};
    run_frame(1, dq, 1'b0, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Byte-stream framer between the UART receiver and `inst_fetch`. It parses a framed program image arriving as single-cycle byte strobes and validates the length. It then drives the `input_start` / `input_data` / `input_valid` / `input_end` loader port of `inst_fetch`, checks an XOR checksum, and reports status. It owns the decision of when instruction memory is being written. `inst_fetch` only consumes the byte strobes.

## Interface
- `INST_MEM_WIDTH`, 2, log2 of instruction memory depth in 32-bit words; must match `inst_fetch`.
- `TIMEOUT`, 100000, maximum idle cycles between bytes while a frame is open.
- `CLK`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `rx_data`  in  8  byte from UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid this cycle.
- `input_data`  out  8  byte to `inst_fetch`.
- `input_valid`  out  1  one-cycle strobe qualifying `input_data`.
- `input_start`  out  1  one-cycle pulse opening a load.
- `input_end`  out  1  one-cycle pulse closing a load.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  sticky; last frame loaded with good checksum.
- `error`  out  1  sticky; last frame failed (bad length, checksum or timeout).

## Operation
- Frame format:
  - magic byte 0xAA.
  - LEN_LO, then LEN_HI: 16-bit little-endian word count N.
  - 4·N data bytes, in the order `inst_fetch` expects.
  - One checksum byte, equal to the XOR of all data bytes.
- States: IDLE, LEN0, LEN1, DATA, CSUM.
- IDLE:
  - Non-0xAA bytes are ignored.
  - 0xAA moves to LEN0 and clears `done`, `error`, the checksum register and the byte counter.
- LEN0: latch the low byte, go to LEN1.
- LEN1: latch the high byte, then check N.
  - N = 0 or N > 2^INST_MEM_WIDTH: set `error` and return to IDLE with no `input_start`.
  - Otherwise pulse `input_start` and go to DATA.
- DATA:
  - Each `rx_valid` copies `rx_data` to `input_data`, pulses `input_valid`, XORs the byte into the checksum and increments an 18-bit byte counter.
  - When the counter reaches 4·N, go to CSUM.
- CSUM:
  - On the byte, pulse `input_end`.
  - Set `done` if the byte equals the checksum; otherwise set `error`.
  - Return to IDLE.
- Timeout:
  - A counter runs in LEN0, LEN1, DATA and CSUM and is cleared on every `rx_valid`.
  - On reaching TIMEOUT: set `error` and return to IDLE.
  - If `input_start` was already issued (DATA or CSUM), also pulse `input_end` so `inst_fetch` leaves load mode.
- Length arithmetic: 4·N is computed as {N, 2'b00} in 18 bits; no overflow is possible.

## Timing
- All outputs are registered.
- Reset values: `input_data` = 0x00, and `input_valid`, `input_start`, `input_end`, `busy`, `done`, `error` = 0. State resets to IDLE.
- Latency from `rx_valid` sampled at edge k:
  - `input_valid` and `input_data` are driven high/valid for the cycle after edge k.
  - In LEN1, `input_start` is likewise valid for the cycle after edge k.
  - In CSUM, `input_end` is likewise valid for the cycle after edge k.
- `input_valid`, `input_start` and `input_end` are each exactly one cycle wide and are never asserted together.
- The earliest first `input_valid` is one cycle after `input_start`. This holds because `rx_valid` strobes are at least 2 cycles apart (UART rate).
- `input_data` holds its value until the next data byte.
- `done` and `error` are mutually exclusive. They stay set until the next 0xAA in IDLE or until reset.
- `busy` goes high the cycle after the magic byte is accepted and low the cycle after returning to IDLE.
- Reset mid-frame: all outputs drop asynchronously and no `input_end` is generated. `inst_fetch` is reset by the same signal.
- If `rx_valid` coincides with the TIMEOUT expiry, the byte wins and the counter clears.

## Test plan
- **Good frame, INST_MEM_WIDTH=2.** Bytes AA 01 00 04 10 C2 00 D6 -> one `input_start`, then four `input_valid` pulses carrying 04, 10, C2, 00, then `input_end`; `done`=1, `error`=0, `busy`=0 afterwards.
- **Bad checksum.** Same frame with last byte 00 -> identical strobes, `input_end` pulses, `error`=1, `done`=0.
- **Length out of range.** AA 05 00 (N=5 > 4), then AA 00 00 (N=0) -> `error`=1 after each, no `input_start`, no `input_valid`, state IDLE.
- **Noise and re-arm.** Bytes 12 34 before AA 01 00 … -> 12 and 34 produce no output. A following good frame clears a prior `error` and ends with `done`=1.
- **Timeout in DATA.** With TIMEOUT=50, send AA 01 00 04 10 then nothing -> `input_end` pulses 50 cycles after the byte 10 strobe, `error`=1, `busy`=0.
- **Reset mid-frame.** Assert `reset`=0 after the second data byte -> all outputs are 0 immediately. After release, a complete good frame loads normally.
